digital_timer_core: RTL and testbench

DIGITAL_TIMER_CORE -- requirements
Module: digital_timer_core

---
 rtl/digital_timer_core.sv | 251 +++++++++++++++++++++++++
 tb/tb_digital_timer_core.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/digital_timer_core.sv
// Stopwatch/countdown timer core with set mode, lap buffer and time-up LED blink.
// Single-cycle control pulses are arbitrated by a fixed priority; only the top pulse acts.
module digital_timer_core #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int MAX_MIN   = 59,
    parameter int LAP_DEPTH = 4,
    parameter int BLINK_DIV = 20_000_000,
    localparam int MW = $clog2(MAX_MIN + 1),
    localparam int LW = $clog2(LAP_DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          mode_tick_i,
    input  logic          start_tick_i,
    input  logic          pause_tick_i,
    input  logic          lap_tick_i,
    input  logic          set_tick_i,
    input  logic          adj_tick_i,
    input  logic          lap_next_tick_i,
    output logic [MW-1:0] cnt_min_o,
    output logic [5:0]    cnt_sec_o,
    output logic [MW-1:0] lap_min_o,
    output logic [5:0]    lap_sec_o,
    output logic [LW:0]   lap_count_o,
    output logic          lap_ovf_o,
    output logic [1:0]    state_o,
    output logic          mode_o,
    output logic          set_active_o,
    output logic          set_field_o,
    output logic          led_o
);

    localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [MW-1:0] MIN_MAX  = MW'(MAX_MIN);
    localparam logic [5:0]    SEC_MAX  = 6'd59;
    localparam logic [LW:0]   LAP_FULL = (LW+1)'(LAP_DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUNNING = 2'b01,
        PAUSED  = 2'b10,
        TIME_UP = 2'b11
    } state_e;

    state_e          state_q, state_d;
    logic            mode_q, mode_d;
    logic [MW-1:0]   cntMin_q, cntMin_d, presetMin_q, presetMin_d, editMin_q, editMin_d;
    logic [5:0]      cntSec_q, cntSec_d, presetSec_q, presetSec_d, editSec_q, editSec_d;
    logic            setActive_q, setActive_d, setField_q, setField_d;
    logic [MW-1:0]   lapMemMin_q [LAP_DEPTH];
    logic [MW-1:0]   lapMemMin_d [LAP_DEPTH];
    logic [5:0]      lapMemSec_q [LAP_DEPTH];
    logic [5:0]      lapMemSec_d [LAP_DEPTH];
    logic [LW-1:0]   wrPtr_q, wrPtr_d, rdIdx_q, rdIdx_d, oldestIdx;
    logic [LW:0]     lapCount_q, lapCount_d;
    logic            lapOvf_q, lapOvf_d;
    logic [MW-1:0]   lapOutMin_q, lapOutMin_d;
    logic [5:0]      lapOutSec_q, lapOutSec_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [BW-1:0]   blinkCnt_q, blinkCnt_d;
    logic            led_q, led_d;
    logic            tick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            cntMin_q    <= '0;
            cntSec_q    <= '0;
            presetMin_q <= MIN_MAX;
            presetSec_q <= SEC_MAX;
            editMin_q   <= '0;
            editSec_q   <= '0;
            setActive_q <= 1'b0;
            setField_q  <= 1'b0;
            for (int i = 0; i < LAP_DEPTH; i++) begin
                lapMemMin_q[i] <= '0;
                lapMemSec_q[i] <= '0;
            end
            wrPtr_q     <= '0;
            rdIdx_q     <= '0;
            lapCount_q  <= '0;
            lapOvf_q    <= 1'b0;
            lapOutMin_q <= '0;
            lapOutSec_q <= '0;
            presc_q     <= '0;
            blinkCnt_q  <= '0;
            led_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            cntMin_q    <= cntMin_d;
            cntSec_q    <= cntSec_d;
            presetMin_q <= presetMin_d;
            presetSec_q <= presetSec_d;
            editMin_q   <= editMin_d;
            editSec_q   <= editSec_d;
            setActive_q <= setActive_d;
            setField_q  <= setField_d;
            lapMemMin_q <= lapMemMin_d;
            lapMemSec_q <= lapMemSec_d;
            wrPtr_q     <= wrPtr_d;
            rdIdx_q     <= rdIdx_d;
            lapCount_q  <= lapCount_d;
            lapOvf_q    <= lapOvf_d;
            lapOutMin_q <= lapOutMin_d;
            lapOutSec_q <= lapOutSec_d;
            presc_q     <= presc_d;
            blinkCnt_q  <= blinkCnt_d;
            led_q       <= led_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        cntMin_d    = cntMin_q;
        cntSec_d    = cntSec_q;
        presetMin_d = presetMin_q;
        presetSec_d = presetSec_q;
        editMin_d   = editMin_q;
        editSec_d   = editSec_q;
        setActive_d = setActive_q;
        setField_d  = setField_q;
        lapMemMin_d = lapMemMin_q;
        lapMemSec_d = lapMemSec_q;
        wrPtr_d     = wrPtr_q;
        rdIdx_d     = rdIdx_q;
        lapCount_d  = lapCount_q;
        lapOvf_d    = lapOvf_q;
        oldestIdx   = (lapCount_q == LAP_FULL) ? wrPtr_q : '0;
        tick        = (state_q == RUNNING) && (presc_q == PW'(CLK_FREQ - 1));
        presc_d     = (state_q == RUNNING && !tick) ? presc_q + PW'(1) : '0;

        // Second tick first, so any same-cycle event that loads the count wins.
        if (tick) begin
            if (!mode_q) begin
                if (cntSec_q == SEC_MAX) begin
                    cntSec_d = '0;
                    cntMin_d = (cntMin_q == MIN_MAX) ? '0 : cntMin_q + MW'(1);
                end else begin
                    cntSec_d = cntSec_q + 6'd1;
                end
            end else if (cntSec_q != '0) begin
                cntSec_d = cntSec_q - 6'd1;
            end else if (cntMin_q != '0) begin
                cntSec_d = SEC_MAX;
                cntMin_d = cntMin_q - MW'(1);
            end
        end
        if (state_q == RUNNING && mode_q && cntMin_q == '0 && cntSec_q == '0)
            state_d = TIME_UP;

        if (mode_tick_i) begin
            if (!setActive_q) begin
                mode_d     = ~mode_q;
                state_d    = IDLE;
                cntMin_d   = mode_q ? '0 : presetMin_q;
                cntSec_d   = mode_q ? '0 : presetSec_q;
                wrPtr_d    = '0;
                rdIdx_d    = '0;
                lapCount_d = '0;
                lapOvf_d   = 1'b0;
                for (int i = 0; i < LAP_DEPTH; i++) begin
                    lapMemMin_d[i] = '0;
                    lapMemSec_d[i] = '0;
                end
            end
        end else if (set_tick_i) begin
            if (state_q == IDLE || state_q == TIME_UP) begin
                setActive_d = ~setActive_q;
                if (!setActive_q) begin
                    editMin_d  = presetMin_q;
                    editSec_d  = presetSec_q;
                    setField_d = 1'b0;
                end else begin
                    presetMin_d = editMin_q;
                    presetSec_d = editSec_q;
                    if (mode_q) begin
                        cntMin_d = editMin_q;
                        cntSec_d = editSec_q;
                        state_d  = IDLE;
                    end
                end
            end
        end else if (start_tick_i) begin
            if (setActive_q) begin
                setField_d = ~setField_q;
            end else begin
                case (state_q)
                    IDLE:    if (!(mode_q && cntMin_q == '0 && cntSec_q == '0)) state_d = RUNNING;
                    PAUSED:  state_d = RUNNING;
                    TIME_UP: state_d = IDLE;
                    default: ;
                endcase
            end
        end else if (pause_tick_i) begin
            if (state_q == RUNNING) state_d = PAUSED;
        end else if (adj_tick_i) begin
            if (setActive_q) begin
                if (!setField_q) editSec_d = (editSec_q == SEC_MAX) ? '0 : editSec_q + 6'd1;
                else             editMin_d = (editMin_q == MIN_MAX) ? '0 : editMin_q + MW'(1);
            end
        end else if (lap_tick_i) begin
            if (!mode_q && !setActive_q && (state_q == RUNNING || state_q == PAUSED)) begin
                lapMemMin_d[wrPtr_q] = cntMin_q;
                lapMemSec_d[wrPtr_q] = cntSec_q;
                rdIdx_d = wrPtr_q;
                wrPtr_d = wrPtr_q + LW'(1);
                if (lapCount_q == LAP_FULL) lapOvf_d = 1'b1;
                else                        lapCount_d = lapCount_q + (LW+1)'(1);
            end
        end else if (lap_next_tick_i) begin
            if (lapCount_q != '0)
                rdIdx_d = (rdIdx_q == oldestIdx) ? wrPtr_q - LW'(1) : rdIdx_q - LW'(1);
        end

        // Blink phase restarts on every entry into TIME_UP.
        if (state_q == TIME_UP && state_d == TIME_UP) begin
            if (blinkCnt_q == BW'(BLINK_DIV - 1)) begin
                blinkCnt_d = '0;
                led_d      = ~led_q;
            end else begin
                blinkCnt_d = blinkCnt_q + BW'(1);
                led_d      = led_q;
            end
        end else begin
            blinkCnt_d = '0;
            led_d      = 1'b0;
        end

        lapOutMin_d = (lapCount_q == '0) ? '0 : lapMemMin_q[rdIdx_q];
        lapOutSec_d = (lapCount_q == '0) ? '0 : lapMemSec_q[rdIdx_q];
    end

    always_comb begin
        cnt_min_o    = cntMin_q;
        cnt_sec_o    = cntSec_q;
        lap_min_o    = lapOutMin_q;
        lap_sec_o    = lapOutSec_q;
        lap_count_o  = lapCount_q;
        lap_ovf_o    = lapOvf_q;
        state_o      = state_q;
        mode_o       = mode_q;
        set_active_o = setActive_q;
        set_field_o  = setField_q;
        led_o        = led_q;
    end

endmodule

// File: tb/tb_digital_timer_core.sv
// Directed bench for digital_timer_core with a small clock (10 clocks per second).
// Inputs change and outputs are sampled on the falling edge.
module tb_digital_timer_core;

    localparam logic [6:0] EV_MODE  = 7'b1000000;
    localparam logic [6:0] EV_SET   = 7'b0100000;
    localparam logic [6:0] EV_START = 7'b0010000;
    localparam logic [6:0] EV_PAUSE = 7'b0001000;
    localparam logic [6:0] EV_ADJ   = 7'b0000100;
    localparam logic [6:0] EV_LAP   = 7'b0000010;
    localparam logic [6:0] EV_NEXT  = 7'b0000001;

    logic       clk = 1'b0;
    logic       reset;
    logic       modeTick, startTick, pauseTick, lapTick, setTick, adjTick, lapNextTick;
    logic [5:0] cntMin, cntSec, lapMin, lapSec;
    logic [2:0] lapCount;
    logic       lapOvf, mode, setActive, setField, led;
    logic [1:0] state;
    int         errors = 0;
    int         checks = 0;

    digital_timer_core #(
        .CLK_FREQ(10), .MAX_MIN(59), .LAP_DEPTH(4), .BLINK_DIV(5)
    ) dut (
        .clk(clk), .reset(reset),
        .mode_tick_i(modeTick), .start_tick_i(startTick), .pause_tick_i(pauseTick),
        .lap_tick_i(lapTick), .set_tick_i(setTick), .adj_tick_i(adjTick),
        .lap_next_tick_i(lapNextTick),
        .cnt_min_o(cntMin), .cnt_sec_o(cntSec), .lap_min_o(lapMin), .lap_sec_o(lapSec),
        .lap_count_o(lapCount), .lap_ovf_o(lapOvf), .state_o(state), .mode_o(mode),
        .set_active_o(setActive), .set_field_o(setField), .led_o(led)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [6:0] ev);
        @(negedge clk);
        {modeTick, setTick, startTick, pauseTick, adjTick, lapTick, lapNextTick} = ev;
        @(negedge clk);
        {modeTick, setTick, startTick, pauseTick, adjTick, lapTick, lapNextTick} = '0;
    endtask

    task automatic waitClocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        reset = 1'b1;
        {modeTick, setTick, startTick, pauseTick, adjTick, lapTick, lapNextTick} = '0;
        waitClocks(3);
        checkOutput("rst_state", 32'(state), 0);
        checkOutput("rst_mode", 32'(mode), 0);
        checkOutput("rst_cnt", 32'({cntMin, cntSec}), 0);
        checkOutput("rst_led", 32'(led), 0);
        checkOutput("rst_lapcnt", 32'(lapCount), 0);
        reset = 1'b0;

        // Stopwatch counting and full wrap from 59:59.
        applyStimulus(EV_START);
        checkOutput("sw_run", 32'(state), 1);
        waitClocks(600);
        checkOutput("sw_1min_m", 32'(cntMin), 1);
        checkOutput("sw_1min_s", 32'(cntSec), 0);
        waitClocks(35390);
        checkOutput("sw_max_m", 32'(cntMin), 59);
        checkOutput("sw_max_s", 32'(cntSec), 59);
        waitClocks(10);
        checkOutput("sw_wrap", 32'({cntMin, cntSec}), 0);
        checkOutput("sw_wrap_state", 32'(state), 1);

        // Ignored set while running, pause masks a simultaneous lap.
        applyStimulus(EV_SET);
        checkOutput("set_ignored", 32'(setActive), 0);
        checkOutput("set_ign_state", 32'(state), 1);
        applyStimulus(EV_PAUSE | EV_LAP);
        checkOutput("pause_state", 32'(state), 2);
        checkOutput("pause_nolap", 32'(lapCount), 0);
        applyStimulus(EV_MODE);
        checkOutput("mode_timer", 32'(mode), 1);
        checkOutput("mode_idle", 32'(state), 0);
        checkOutput("mode_preset_m", 32'(cntMin), 59);
        checkOutput("mode_preset_s", 32'(cntSec), 59);
        applyStimulus(EV_MODE | EV_START);
        checkOutput("modestart_mode", 32'(mode), 0);
        checkOutput("modestart_state", 32'(state), 0);
        checkOutput("modestart_cnt", 32'({cntMin, cntSec}), 0);

        // Five laps into a four-entry buffer.
        applyStimulus(EV_START);
        for (int i = 1; i <= 5; i++) begin
            waitClocks(i == 1 ? 10 : 9);
            applyStimulus(EV_LAP);
        end
        waitClocks(1);
        checkOutput("lap_count", 32'(lapCount), 4);
        checkOutput("lap_ovf", 32'(lapOvf), 1);
        checkOutput("lap_newest", 32'({lapMin, lapSec}), 5);
        applyStimulus(EV_NEXT);
        waitClocks(1);
        checkOutput("lap_next1", 32'({lapMin, lapSec}), 4);
        applyStimulus(EV_NEXT);
        waitClocks(1);
        checkOutput("lap_next2", 32'({lapMin, lapSec}), 3);
        applyStimulus(EV_NEXT);
        waitClocks(1);
        checkOutput("lap_next3", 32'({lapMin, lapSec}), 2);
        applyStimulus(EV_NEXT);
        waitClocks(1);
        checkOutput("lap_wrap", 32'({lapMin, lapSec}), 5);

        // Timer: program 00:03, run down, blink, acknowledge.
        applyStimulus(EV_MODE);
        checkOutput("tm_mode", 32'(mode), 1);
        checkOutput("tm_lapclr", 32'({lapOvf, lapCount}), 0);
        waitClocks(1);
        checkOutput("tm_lapout", 32'({lapMin, lapSec}), 0);
        applyStimulus(EV_SET);
        checkOutput("tm_setact", 32'(setActive), 1);
        checkOutput("tm_setfield0", 32'(setField), 0);
        repeat (4) applyStimulus(EV_ADJ);
        applyStimulus(EV_START);
        checkOutput("tm_setfield1", 32'(setField), 1);
        applyStimulus(EV_ADJ);
        applyStimulus(EV_SET);
        checkOutput("tm_setexit", 32'(setActive), 0);
        checkOutput("tm_load_m", 32'(cntMin), 0);
        checkOutput("tm_load_s", 32'(cntSec), 3);
        applyStimulus(EV_START);
        checkOutput("tm_run", 32'(state), 1);
        waitClocks(10);
        checkOutput("tm_2s", 32'(cntSec), 2);
        waitClocks(20);
        checkOutput("tm_zero", 32'({cntMin, cntSec}), 0);
        checkOutput("tm_zero_state", 32'(state), 1);
        waitClocks(1);
        checkOutput("tm_timeup", 32'(state), 3);
        checkOutput("tm_led_entry", 32'(led), 0);
        waitClocks(4);
        checkOutput("tm_led_pre", 32'(led), 0);
        waitClocks(1);
        checkOutput("tm_led_on", 32'(led), 1);
        waitClocks(5);
        checkOutput("tm_led_off", 32'(led), 0);
        waitClocks(5);
        checkOutput("tm_led_on2", 32'(led), 1);
        applyStimulus(EV_START);
        checkOutput("tm_ack_state", 32'(state), 0);
        checkOutput("tm_ack_led", 32'(led), 0);
        applyStimulus(EV_START);
        checkOutput("tm_zero_nostart", 32'(state), 0);

        // Asynchronous reset in the middle of a stopwatch run.
        applyStimulus(EV_MODE);
        applyStimulus(EV_START);
        waitClocks(15);
        applyStimulus(EV_LAP);
        waitClocks(1);
        checkOutput("pre_rst_lap", 32'(lapCount), 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("arst_state", 32'(state), 0);
        checkOutput("arst_cnt", 32'({cntMin, cntSec}), 0);
        checkOutput("arst_lap", 32'({lapOvf, lapCount, lapMin, lapSec}), 0);
        checkOutput("arst_misc", 32'({mode, setActive, setField, led}), 0);
        @(negedge clk);
        reset = 1'b0;
        waitClocks(3);
        checkOutput("post_rst_idle", 32'({state, cntMin, cntSec}), 0);
        applyStimulus(EV_MODE);
        checkOutput("post_rst_preset", 32'({cntMin, cntSec}), 32'({6'd59, 6'd59}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
